// File: rtl/tlul_scratchpad_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : tlul_scratchpad_pipe_if
// Brief   : TL-UL A/D channel bundle for the scratchpad slave.
// Revision: 1.0
// ============================================================================
interface tlul_scratchpad_pipe_if #(
    parameter int unsigned DW   = 64,
    parameter int unsigned AW   = 32,
    parameter int unsigned SrcW = 8,
    parameter int unsigned SzW  = 3
);
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [SzW-1:0]    a_size;
    logic [SrcW-1:0]   a_source;
    logic [AW-1:0]     a_address;
    logic [DW/8-1:0]   a_mask;
    logic [DW-1:0]     a_data;
    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [SzW-1:0]    d_size;
    logic [SrcW-1:0]   d_source;
    logic              d_error;
    logic [DW-1:0]     d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_error, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_error, d_data
    );
endinterface
`default_nettype wire

// File: rtl/tlul_scratchpad_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tlul_scratchpad_pipe
// Brief   : TL-UL scratchpad RAM slave with credit flow control and reset-time zero sweep.
// Revision: 1.0
// ============================================================================
module tlul_scratchpad_pipe #(
    parameter int unsigned DW          = 64,
    parameter int unsigned AW          = 32,
    parameter int unsigned SrcW        = 8,
    parameter int unsigned SzW         = 3,
    parameter logic [AW-1:0] BaseAddr  = '0,
    parameter int unsigned DepthBytes  = 256,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned RspDepth    = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    tlul_scratchpad_pipe_if.slave      tl,
    output logic                       init_done
);
    localparam int unsigned c_bytes = DW / 8;
    localparam int unsigned c_words = DepthBytes / c_bytes;
    localparam int unsigned c_lb    = $clog2(c_bytes);
    localparam int unsigned c_iw    = $clog2(c_words);
    localparam int unsigned c_cw    = $clog2(RspDepth + 1) + 1;
    localparam int unsigned c_pw    = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]        r_state;
    logic [c_iw-1:0]   r_init_idx;
    logic              r_init_done;
    logic [DW-1:0]     r_mem [c_words];

    // ---------------- request decode ----------------
    logic [AW-1:0]     w_off;
    logic [c_iw-1:0]   w_idx;
    logic              w_in_range, w_op_ok, w_size_ok, w_align_ok, w_mask_ok;
    logic [c_bytes-1:0] w_exp_mask;
    logic              w_err, w_is_get, w_accept, w_wr_en, w_init_we;

    assign w_off      = tl.a_address - BaseAddr;
    assign w_idx      = c_iw'(w_off >> c_lb);
    assign w_in_range = (tl.a_address >= BaseAddr) && (w_off < AW'(DepthBytes));
    assign w_op_ok    = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1) || (tl.a_opcode == 3'd4);
    assign w_size_ok  = (tl.a_size <= SzW'(c_lb));
    assign w_is_get   = (tl.a_opcode == 3'd4);

    // Lanes covered by the sized/aligned beat, used for both alignment and full-mask checks
    always_comb begin
        w_align_ok = 1'b1;
        w_exp_mask = '0;
        for (int b = 0; b < int'(c_lb); b++) begin
            if ((b < int'(tl.a_size)) && tl.a_address[b]) w_align_ok = 1'b0;
        end
        for (int l = 0; l < int'(c_bytes); l++) begin
            if ((l >> tl.a_size) == (int'(tl.a_address[c_lb-1:0]) >> tl.a_size))
                w_exp_mask[l] = 1'b1;
        end
    end

    assign w_mask_ok = (tl.a_opcode != 3'd0) || (tl.a_mask == w_exp_mask);
    assign w_err     = !(w_in_range && w_op_ok && w_size_ok && w_align_ok && w_mask_ok);
    assign w_accept  = tl.a_valid && tl.a_ready;
    assign w_wr_en   = w_accept && !w_err && !w_is_get;
    assign w_init_we = (r_state == c_st_init);

    // ---------------- init FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_st_init;
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == c_st_init) begin
            r_init_idx <= r_init_idx + 1'b1;
            if (r_init_idx == c_iw'(c_words - 1)) begin
                r_state     <= c_st_run;
                r_init_done <= 1'b1;
            end
        end
    end

    assign init_done = r_init_done;

    // Zero sweep and bus writes never coincide: a_ready is held low during INIT
    always_ff @(posedge clk_i) begin
        if (w_init_we) begin
            r_mem[r_init_idx] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < int'(c_bytes); b++) begin
                if (tl.a_mask[b]) r_mem[w_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
            end
        end
    end

    // ---------------- read pipeline ----------------
    logic [ReadLatency-1:0] r_pv, r_pget, r_perr;
    logic [SzW-1:0]         r_psize [ReadLatency];
    logic [SrcW-1:0]        r_psrc  [ReadLatency];
    logic [DW-1:0]          r_pdata [ReadLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pv   <= '0;
            r_pget <= '0;
            r_perr <= '0;
            for (int k = 0; k < int'(ReadLatency); k++) begin
                r_psize[k] <= '0;
                r_psrc[k]  <= '0;
                r_pdata[k] <= '0;
            end
        end else begin
            r_pv[0]    <= w_accept;
            r_pget[0]  <= w_is_get;
            r_perr[0]  <= w_err;
            r_psize[0] <= tl.a_size;
            r_psrc[0]  <= tl.a_source;
            r_pdata[0] <= (w_accept && w_is_get && !w_err) ? r_mem[w_idx] : '0;
            for (int k = 1; k < int'(ReadLatency); k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_pget[k]  <= r_pget[k-1];
                r_perr[k]  <= r_perr[k-1];
                r_psize[k] <= r_psize[k-1];
                r_psrc[k]  <= r_psrc[k-1];
                r_pdata[k] <= r_pdata[k-1];
            end
        end
    end

    // ---------------- response FIFO (first-word fall-through) ----------------
    logic              r_fget  [RspDepth];
    logic              r_ferr  [RspDepth];
    logic [SzW-1:0]    r_fsize [RspDepth];
    logic [SrcW-1:0]   r_fsrc  [RspDepth];
    logic [DW-1:0]     r_fdata [RspDepth];
    logic [c_pw-1:0]   r_wptr, r_rptr;
    logic [c_cw-1:0]   r_count;
    logic [c_cw-1:0]   w_inflight, w_credits;
    logic              w_empty, w_lv, w_pop, w_bypass, w_push;

    assign w_lv     = r_pv[ReadLatency-1];
    assign w_empty  = (r_count == '0);
    assign w_pop    = !w_empty && tl.d_ready;
    assign w_bypass = w_empty && w_lv && tl.d_ready;
    assign w_push   = w_lv && !w_bypass;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < int'(ReadLatency); k++) w_inflight += c_cw'(r_pv[k]);
    end

    // Every accepted request already owns a FIFO slot, so the pipeline never stalls
    assign w_credits  = c_cw'(RspDepth) - r_count - w_inflight;
    assign tl.a_ready = (r_state == c_st_run) && (w_credits != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int k = 0; k < int'(RspDepth); k++) begin
                r_fget[k]  <= 1'b0;
                r_ferr[k]  <= 1'b0;
                r_fsize[k] <= '0;
                r_fsrc[k]  <= '0;
                r_fdata[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fget[r_wptr]  <= r_pget[ReadLatency-1];
                r_ferr[r_wptr]  <= r_perr[ReadLatency-1];
                r_fsize[r_wptr] <= r_psize[ReadLatency-1];
                r_fsrc[r_wptr]  <= r_psrc[ReadLatency-1];
                r_fdata[r_wptr] <= r_pdata[ReadLatency-1];
                r_wptr <= (r_wptr == c_pw'(RspDepth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_pw'(RspDepth - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign tl.d_valid  = !w_empty || w_lv;
    assign tl.d_opcode = {2'b00, w_empty ? r_pget[ReadLatency-1] : r_fget[r_rptr]};
    assign tl.d_error  = w_empty ? r_perr[ReadLatency-1]  : r_ferr[r_rptr];
    assign tl.d_size   = w_empty ? r_psize[ReadLatency-1] : r_fsize[r_rptr];
    assign tl.d_source = w_empty ? r_psrc[ReadLatency-1]  : r_fsrc[r_rptr];
    assign tl.d_data   = w_empty ? r_pdata[ReadLatency-1] : r_fdata[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_tlul_scratchpad_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlul_scratchpad_pipe
// Brief   : Directed self-checking bench for tlul_scratchpad_pipe (latency 1 and 3).
// Revision: 1.0
// ============================================================================
module tb_tlul_scratchpad_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done0, done1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tlul_scratchpad_pipe_if #(.DW(64), .AW(32), .SrcW(8), .SzW(3)) bus0 ();
    tlul_scratchpad_pipe_if #(.DW(64), .AW(32), .SrcW(8), .SzW(3)) bus1 ();

    tlul_scratchpad_pipe #(.ReadLatency(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .tl(bus0.slave), .init_done(done0)
    );
    tlul_scratchpad_pipe #(.ReadLatency(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .tl(bus1.slave), .init_done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on dut0 with d_ready=1; response must appear one cycle after accept
    task automatic txn(input string tag, input logic [2:0] op, input logic [2:0] sz,
                       input logic [7:0] src, input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic exp_err, input logic [63:0] exp_data);
        int n = 0;
        bus0.a_valid = 1'b1; bus0.a_opcode = op; bus0.a_size = sz; bus0.a_source = src;
        bus0.a_address = addr; bus0.a_mask = mask; bus0.a_data = data; bus0.d_ready = 1'b1;
        while (!bus0.a_ready && n < 20) begin tick(); n++; end
        chk({tag, " a_ready"}, 64'(bus0.a_ready), 64'd1);
        tick();
        bus0.a_valid = 1'b0;
        chk({tag, " d_valid"},  64'(bus0.d_valid),  64'd1);
        chk({tag, " d_opcode"}, 64'(bus0.d_opcode), (op == 3'd4) ? 64'd1 : 64'd0);
        chk({tag, " d_error"},  64'(bus0.d_error),  64'(exp_err));
        chk({tag, " d_data"},   bus0.d_data,        exp_data);
        chk({tag, " d_source"}, 64'(bus0.d_source), 64'(src));
        chk({tag, " d_size"},   64'(bus0.d_size),   64'(sz));
        tick();
    endtask

    initial begin : main
        int n;
        int acc;
        logic w;
        logic [31:0] bp_addr [8];
        logic [63:0] bp_exp  [4];
        bp_addr = '{32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30, 32'h38, 32'h40};
        bp_exp  = '{64'hAAAA_AAAA_5566_7788, 64'h0000_0000_FFFF_FFFF, 64'h0, 64'h0};

        bus0.a_valid = 1'b0; bus0.a_opcode = '0; bus0.a_size = '0; bus0.a_source = '0;
        bus0.a_address = '0; bus0.a_mask = '0; bus0.a_data = '0; bus0.d_ready = 1'b0;
        bus1.a_valid = 1'b0; bus1.a_opcode = '0; bus1.a_size = '0; bus1.a_source = '0;
        bus1.a_address = '0; bus1.a_mask = '0; bus1.a_data = '0; bus1.d_ready = 1'b1;

        // Reset state and zero-sweep duration
        tick(); tick();
        chk("rst a_ready",   64'(bus0.a_ready), 64'd0);
        chk("rst d_valid",   64'(bus0.d_valid), 64'd0);
        chk("rst init_done", 64'(done0),        64'd0);
        rst_n = 1'b1;
        n = 0;
        tick(); n++;
        chk("init a_ready low", 64'(bus0.a_ready), 64'd0);
        while (!done0 && n < 100) begin tick(); n++; end
        chk("init cycles", 64'(n), 64'd32);
        chk("run a_ready", 64'(bus0.a_ready), 64'd1);

        for (int i = 0; i < 32; i++)
            txn($sformatf("zero[%0d]", i), 3'd4, 3'd3, 8'(i), 32'(i * 8), 8'hFF, 64'h0, 1'b0, 64'h0);

        txn("put08",   3'd0, 3'd3, 8'h21, 32'h08, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0);
        txn("get08",   3'd4, 3'd3, 8'h22, 32'h08, 8'hFF, 64'h0, 1'b0, 64'h1122_3344_5566_7788);
        txn("ppart10", 3'd1, 3'd3, 8'h23, 32'h10, 8'h0F, '1,    1'b0, 64'h0);
        txn("get10",   3'd4, 3'd3, 8'h24, 32'h10, 8'hFF, 64'h0, 1'b0, 64'h0000_0000_FFFF_FFFF);
        txn("oor100",  3'd4, 3'd3, 8'h25, 32'h100, 8'hFF, 64'h0, 1'b1, 64'h0);
        txn("op2",     3'd2, 3'd3, 8'h26, 32'h08, 8'hFF, '1,    1'b1, 64'h0);
        txn("get08b",  3'd4, 3'd3, 8'h27, 32'h08, 8'hFF, 64'h0, 1'b0, 64'h1122_3344_5566_7788);
        txn("misalign",3'd4, 3'd3, 8'h28, 32'h04, 8'hFF, 64'h0, 1'b1, 64'h0);
        txn("size4",   3'd4, 3'd4, 8'h29, 32'h00, 8'hFF, 64'h0, 1'b1, 64'h0);
        txn("badmask", 3'd0, 3'd2, 8'h2A, 32'h0C, 8'h0F, '1,    1'b1, 64'h0);
        txn("put0c",   3'd0, 3'd2, 8'h2B, 32'h0C, 8'hF0, 64'hAAAA_AAAA_0000_0000, 1'b0, 64'h0);
        txn("get08c",  3'd4, 3'd3, 8'h2C, 32'h08, 8'hFF, 64'h0, 1'b0, 64'hAAAA_AAAA_5566_7788);

        // Backpressure: exactly RspDepth accepts with d_ready low
        bus0.d_ready = 1'b0; bus0.a_valid = 1'b1; bus0.a_opcode = 3'd4; bus0.a_size = 3'd3;
        bus0.a_mask = 8'hFF; acc = 0;
        for (int c = 0; c < 10; c++) begin
            bus0.a_address = bp_addr[acc];
            bus0.a_source  = 8'(acc);
            w = bus0.a_ready;
            tick();
            if (w) acc++;
        end
        bus0.a_valid = 1'b0;
        chk("bp accepts",  64'(acc), 64'd4);
        chk("bp a_ready",  64'(bus0.a_ready), 64'd0);
        chk("bp hold data", bus0.d_data, bp_exp[0]);
        tick();
        chk("bp hold stable", bus0.d_data, bp_exp[0]);
        bus0.d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp[%0d] d_valid", k),  64'(bus0.d_valid),  64'd1);
            chk($sformatf("bp[%0d] d_source", k), 64'(bus0.d_source), 64'(k));
            chk($sformatf("bp[%0d] d_data", k),   bus0.d_data,        bp_exp[k]);
            tick();
        end
        chk("bp drained", 64'(bus0.d_valid), 64'd0);
        chk("bp credits", 64'(bus0.a_ready), 64'd1);

        // Reset in the middle of pending responses
        bus0.d_ready = 1'b0; bus0.a_valid = 1'b1; bus0.a_address = 32'h08; bus0.a_source = 8'h50;
        tick(); tick();
        bus0.a_valid = 1'b0;
        chk("mid pending", 64'(bus0.d_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst d_valid",   64'(bus0.d_valid), 64'd0);
        chk("mid rst a_ready",   64'(bus0.a_ready), 64'd0);
        chk("mid rst init_done", 64'(done0),        64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!done0 && n < 100) begin tick(); n++; end
        chk("reinit cycles", 64'(n), 64'd32);
        txn("rezero08", 3'd4, 3'd3, 8'h51, 32'h08, 8'hFF, 64'h0, 1'b0, 64'h0);
        txn("rezero10", 3'd4, 3'd3, 8'h52, 32'h10, 8'hFF, 64'h0, 1'b0, 64'h0);

        // Latency 3: 4 Puts then 4 Gets back to back, one response per cycle from t+3
        chk("rl3 init_done", 64'(done1), 64'd1);
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                bus1.a_valid = 1'b1;
                bus1.a_opcode = (c < 4) ? 3'd0 : 3'd4;
                bus1.a_size = 3'd3; bus1.a_mask = 8'hFF; bus1.a_source = 8'(c);
                bus1.a_address = 32'((c % 4) * 8);
                bus1.a_data = 64'hC0DE_0000_0000_0000 | 64'(c);
                chk($sformatf("rl3 a_ready[%0d]", c), 64'(bus1.a_ready), 64'd1);
            end else begin
                bus1.a_valid = 1'b0;
            end
            chk($sformatf("rl3 d_valid[%0d]", c), 64'(bus1.d_valid), (c >= 3 && c < 11) ? 64'd1 : 64'd0);
            if (c >= 3 && c < 11) begin
                chk($sformatf("rl3 d_source[%0d]", c), 64'(bus1.d_source), 64'(c - 3));
                chk($sformatf("rl3 d_opcode[%0d]", c), 64'(bus1.d_opcode), (c - 3 < 4) ? 64'd0 : 64'd1);
                chk($sformatf("rl3 d_data[%0d]", c), bus1.d_data,
                    (c - 3 < 4) ? 64'h0 : (64'hC0DE_0000_0000_0000 | 64'(c - 7)));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
